// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory; every access is a fixed 3-cycle IDLE/ACCESS/DONE transaction.
// The losing requester is stalled by holding req until its done pulse; requests are only looked at in IDLE.
module dmem_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ptr;
    logic        win;
    logic        win_nxt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        aligned;

    assign aligned = (lat_addr[1:0] == 2'b00);

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        mem_we    = 1'b0;
        mem_a     = 32'h0;
        mem_wd    = 32'h0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = ACCESS;
                    if (req0 && req1) begin
                        win_nxt = RR ? ptr : 1'b0;
                    end else begin
                        win_nxt = req1;
                    end
                end
            end
            ACCESS: begin
                state_nxt = DONE;
                // Gate with reset so an abort on this edge cannot commit the write.
                mem_we    = lat_we && aligned && !reset;
                mem_a     = lat_addr;
                mem_wd    = lat_wdata;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
        end else begin
            state <= state_nxt;
            win   <= win_nxt;
            gnt0  <= (state_nxt == ACCESS) && !win_nxt;
            gnt1  <= (state_nxt == ACCESS) && win_nxt;
            done0 <= (state == ACCESS) && !win;
            done1 <= (state == ACCESS) && win;
            err   <= (state == ACCESS) && !aligned;
            if (state == IDLE && state_nxt == ACCESS) begin
                lat_we    <= win_nxt ? we1    : we0;
                lat_addr  <= win_nxt ? addr1  : addr0;
                lat_wdata <= win_nxt ? wdata1 : wdata0;
            end
            if (state == ACCESS) begin
                rdata <= (!lat_we && aligned) ? mem_rd : 32'h0;
            end
            if (state == DONE && RR) begin
                ptr <= !win;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err, fp_mem_we;
    logic [31:0] fp_rdata, fp_mem_a, fp_mem_wd;

    logic [31:0] tb_mem [0:63];
    logic        mem_init;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference state
    logic [31:0] m_mem [0:63];
    int          m_stage;
    logic        m_ptr, m_win, m_we;
    logic [31:0] m_addr, m_wd;
    logic        e_gnt0, e_gnt1, e_done0, e_done1, e_err;
    logic [31:0] e_rdata;

    int cnt_we, cnt_d0, cnt_d1, cnt_fp0, cnt_fp1;
    logic act0, act1;

    dmem_arbiter #(.RR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .rdata(rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    dmem_arbiter #(.RR(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1),
        .err(fp_err), .rdata(fp_rdata),
        .mem_we(fp_mem_we), .mem_a(fp_mem_a), .mem_wd(fp_mem_wd), .mem_rd(32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
    endfunction

    assign mem_rd = tb_mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_val(i);
        end else if (mem_we) begin
            tb_mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One posedge of the reference: a served request occupies the memory for one
    // cycle, completes the next, and the arbiter is free again the cycle after.
    task automatic model_step();
        logic al;
        if (reset) begin
            m_stage = 0; m_ptr = 1'b0;
            e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_err = 0; e_rdata = 32'h0;
        end else if (m_stage == 0) begin
            e_done0 = 0; e_done1 = 0; e_err = 0;
            if (req0 || req1) begin
                m_win  = (req0 && req1) ? m_ptr : req1;
                m_we   = m_win ? we1 : we0;
                m_addr = m_win ? addr1 : addr0;
                m_wd   = m_win ? wdata1 : wdata0;
                e_gnt0 = !m_win; e_gnt1 = m_win;
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            al = (m_addr % 4) == 0;
            e_rdata = (!m_we && al) ? m_mem[m_addr[7:2]] : 32'h0;
            if (m_we && al) m_mem[m_addr[7:2]] = m_wd;
            e_gnt0 = 0; e_gnt1 = 0;
            e_done0 = !m_win; e_done1 = m_win; e_err = !al;
            m_stage = 2;
        end else begin
            e_done0 = 0; e_done1 = 0; e_err = 0;
            m_ptr = !m_win;
            m_stage = 0;
        end
    endtask

    task automatic check_all();
        logic in_acc;
        in_acc = (m_stage == 1);
        chk1("gnt0", gnt0, e_gnt0);
        chk1("gnt1", gnt1, e_gnt1);
        chk1("done0", done0, e_done0);
        chk1("done1", done1, e_done1);
        chk1("err", err, e_err);
        chk32("rdata", rdata, e_rdata);
        chk1("mem_we", mem_we, in_acc && m_we && (m_addr[1:0] == 2'b00) && !reset);
        chk32("mem_a", mem_a, in_acc ? m_addr : 32'h0);
        chk32("mem_wd", mem_wd, in_acc ? m_wd : 32'h0);
        if (mem_we) cnt_we++;
        if (done0) cnt_d0++;
        if (done1) cnt_d1++;
        if (fp_done0) cnt_fp0++;
        if (fp_done1) cnt_fp1++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic new_txn(output logic we, output logic [31:0] addr, output logic [31:0] wd);
        we   = 1'($urandom_range(0, 1));
        addr = 32'($urandom_range(0, 63)) * 4;
        if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
        wd   = $urandom;
    endtask

    initial begin
        int mism;
        reset = 1'b1; mem_init = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        act0 = 0; act1 = 0;
        cnt_we = 0; cnt_d0 = 0; cnt_d1 = 0; cnt_fp0 = 0; cnt_fp1 = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = init_val(i);
        m_stage = 0; m_ptr = 0; m_win = 0; m_we = 0; m_addr = 0; m_wd = 0;

        tick();
        chk32("reset_rdata", rdata, 32'h0);
        chk1("reset_gnt0", gnt0, 1'b0);
        mem_init = 1'b0; reset = 1'b0;

        // CPU read alone
        req0 = 1; we0 = 0; addr0 = 32'h10;
        tick(); chk1("cpu_rd_gnt0", gnt0, 1'b1);
        tick(); chk1("cpu_rd_done0", done0, 1'b1);
        chk32("cpu_rd_rdata", rdata, 32'hDEADBEEF);
        req0 = 0; tick();

        // DMA write then CPU read of the same word
        cnt_we = 0;
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
        tick(); tick(); chk1("dma_wr_done1", done1, 1'b1);
        req1 = 0; tick();
        req0 = 1; we0 = 0; addr0 = 32'h20;
        tick(); tick();
        chk1("wr_rd_done0", done0, 1'b1);
        chk32("wr_rd_rdata", rdata, 32'h12345678);
        req0 = 0; tick();
        chk32("wr_rd_we_cycles", 32'(cnt_we), 32'd1);

        // Misaligned write
        cnt_we = 0;
        req0 = 1; we0 = 1; addr0 = 32'h22; wdata0 = 32'hFFFFFFFF;
        tick(); tick();
        chk1("mis_done0", done0, 1'b1);
        chk1("mis_err", err, 1'b1);
        chk32("mis_rdata", rdata, 32'h0);
        req0 = 0; tick();
        chk32("mis_we_cycles", 32'(cnt_we), 32'd0);
        chk32("mis_mem20", tb_mem[8], 32'h12345678);

        // Reset in the ACCESS cycle of a write
        req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'hCAFEF00D;
        tick(); chk1("abort_gnt1", gnt1, 1'b1);
        reset = 1; #1;
        chk1("abort_mem_we", mem_we, 1'b0);
        req1 = 0;
        tick();
        reset = 0;
        tick();
        chk1("abort_no_done0", done0, 1'b0);
        chk1("abort_no_done1", done1, 1'b0);
        chk32("abort_mem30", tb_mem[12], init_val(12));
        req0 = 1; we0 = 0; addr0 = 32'h10; req1 = 1; we1 = 0; addr1 = 32'h20;
        tick(); chk1("post_rst_gnt0", gnt0, 1'b1);
        tick(); req0 = 0; req1 = 0; tick();

        // Contention held from reset: RR alternates, fixed priority starves requester 1
        reset = 1; tick(); reset = 0;
        cnt_d0 = 0; cnt_d1 = 0; cnt_fp0 = 0; cnt_fp1 = 0;
        req0 = 1; we0 = 0; addr0 = 32'h10; req1 = 1; we1 = 0; addr1 = 32'h20;
        repeat (24) tick();
        chk32("rr_done0_cnt", 32'(cnt_d0), 32'd4);
        chk32("rr_done1_cnt", 32'(cnt_d1), 32'd4);
        chk32("fp_done0_cnt", 32'(cnt_fp0), 32'd8);
        chk32("fp_done1_cnt", 32'(cnt_fp1), 32'd0);
        req0 = 0; req1 = 0;
        reset = 1; tick(); reset = 0;

        // Random traffic with occasional resets
        repeat (600) begin
            tick();
            if (reset) begin
                reset = 0;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1; act0 = 0; act1 = 0; req0 = 0; req1 = 0;
            end
            if (!reset) begin
                if (act0 && done0) begin
                    act0 = 0; req0 = 0;
                end else if (!act0 && $urandom_range(0, 2) == 0) begin
                    new_txn(we0, addr0, wdata0); act0 = 1; req0 = 1;
                end
                if (act1 && done1) begin
                    act1 = 0; req1 = 0;
                end else if (!act1 && $urandom_range(0, 2) == 0) begin
                    new_txn(we1, addr1, wdata1); act1 = 1; req1 = 1;
                end
            end
        end
        req0 = 0; req1 = 0; reset = 0;
        repeat (3) tick();

        mism = 0;
        for (int i = 0; i < 64; i++) if (tb_mem[i] !== m_mem[i]) mism++;
        chk32("mem_image_mismatches", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter RR, default 1: 1 = round-robin between requesters, 0 = fixed priority to requester 0 (CPU).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req0, req1  input  1 each  access request from CPU (0) and DMA/debug (1) port.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read, per requester.
REQ-006 addr0, addr1  input  32 each  byte address, per requester.
REQ-007 wdata0, wdata1  input  32 each  write data, per requester.
REQ-008 gnt0, gnt1  output  1 each  registered; high while that requester's access occupies the memory.
REQ-009 done0, done1  output  1 each  registered one-cycle completion pulse.
REQ-010 err  output  1  registered; pulses with done when the completed access was misaligned.
REQ-011 rdata  output  32  registered read data, valid in the done cycle.
REQ-012 mem_we  output  1  write enable to the single-port data memory.
REQ-013 mem_a, mem_wd  output  32 each  address and write data to the memory.
REQ-014 mem_rd  input  32  combinational read data from the memory.

Function
REQ-015 FSM states: IDLE, ACCESS, DONE; every transaction takes exactly 3 cycles: IDLE -> ACCESS -> DONE -> IDLE.
REQ-016 Requests are sampled only in IDLE; in ACCESS and DONE, request inputs are ignored for arbitration.
REQ-017 In IDLE with one request high: that requester wins; with neither high: remain in IDLE.
REQ-018 In IDLE with both high and RR=1: the winner is the requester indicated by the priority pointer.
REQ-019 In IDLE with both high and RR=0: requester 0 always wins.
REQ-020 On leaving IDLE, the winner's we, addr and wdata are latched, and the FSM goes to ACCESS.
REQ-021 Latched values alone drive mem_a/mem_wd; requester input changes after the IDLE sample have no effect.
REQ-022 In ACCESS: gnt of the winner is high; mem_a = latched addr; mem_wd = latched wdata.
REQ-023 In ACCESS: mem_we = latched we AND addr[1:0]==0.
REQ-024 In every state other than ACCESS: mem_we = 0, and mem_a and mem_wd = 0.
REQ-025 At the end of ACCESS, rdata captures mem_rd for an aligned read; for writes and misaligned accesses it captures 0.
REQ-026 In DONE, the winner's done is high for exactly one cycle, and gnt is low.
REQ-027 In DONE, err = 1 if latched addr[1:0] != 0, else 0.
REQ-028 In DONE, the priority pointer (RR=1) moves to the non-winning requester; the FSM then returns to IDLE.
REQ-029 A requester holds req/we/addr/wdata stable until its done, then deasserts req the following cycle.
REQ-030 A req still high in the IDLE after DONE is a new request.
REQ-031 At most one of gnt0/gnt1 and one of done0/done1 is ever high.
REQ-032 rdata holds its value until the next DONE.

Reset
REQ-033 While reset is high at a posedge, the FSM enters IDLE, the pointer selects requester 0, and latched addr/wdata/we clear to 0.
REQ-034 On that same reset, gnt0, gnt1, done0, done1, err, rdata, mem_we, mem_a and mem_wd all become 0.
REQ-035 Reset asserted in ACCESS or DONE aborts the transaction: no done pulse is issued, and no memory write occurs on or after the reset edge.

Verification
REQ-036 CPU read alone: memory word at 0x10 = 0xDEADBEEF, req0 with addr0 = 0x10 in IDLE -> gnt0 next cycle, done0 with rdata = 0xDEADBEEF two cycles after sampling.
REQ-037 DMA write then CPU read: req1 writes 0x12345678 to 0x20, then req0 reads 0x20 -> mem_we high for one cycle only, rdata = 0x12345678 on done0.
REQ-038 Contention, RR=1: both requests held continuously from reset -> grants alternate 0,1,0,1 with one done every 3 cycles; with RR=0 -> only requester 0 is served.
REQ-039 Misaligned write: req0, we0 = 1, addr0 = 0x22 -> mem_we stays 0, done0 and err pulse together, the word at 0x20 is unchanged, and rdata = 0.
REQ-040 Reset during ACCESS of a write -> no done, mem_we = 0 from the reset edge, memory is unmodified, and the next request after reset is served by priority to requester 0.
